// File: rtl/evt_engine_merger_if.sv
// SNE event word layout and the valid/ready stream interface that carries it.
package sne_evt_pkg;
  localparam logic [3:0] EVT_IDLE       = 4'h0;
  localparam logic [3:0] EVT_SPIKE      = 4'h1;
  localparam logic [3:0] EVT_ACCUMULATE = 4'h2;
  localparam logic [3:0] EVT_WIPE       = 4'h3;
  localparam logic [3:0] EVT_UPDATE     = 4'h4;
  localparam logic [3:0] EVT_TIME       = 4'h5;
  localparam logic [3:0] EVT_SYNCH      = 4'h6;

  typedef struct packed {
    logic [3:0]  operation;
    logic [3:0]  unit_id;
    logic [7:0]  cid;
    logic [15:0] payload;
  } spike_t;

  typedef struct packed {
    spike_t spike;
  } sne_evt_t;
endpackage

interface SNE_EVENT_STREAM;
  import sne_evt_pkg::*;
  logic     valid;
  logic     ready;
  sne_evt_t evt;

  modport src (output valid, output evt, input ready);
  modport dst (input valid, input evt, output ready);
endinterface

// File: rtl/evt_engine_merger.sv
// Merges spike-class and time-class event streams into one engine-bound stream.
// Optional op-class checking (drop + error count) enabled by EVT_ENGINE_MERGER_OP_CHECK_EN.
module evt_engine_merger
  import sne_evt_pkg::*;
#(
  parameter int ENGINE_ID   = 0,
  parameter int SPIKE_BURST = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         enable_i,
  SNE_EVENT_STREAM.dst evt_stream_spike_dst,
  SNE_EVENT_STREAM.dst evt_stream_time_dst,
  SNE_EVENT_STREAM.src evt_stream_engine_src,
  output logic [15:0]  err_cnt_o,
  output logic         busy_o
);

  if (SPIKE_BURST < 1 || SPIKE_BURST > 255) begin : g_burst_chk
    $error("SPIKE_BURST must lie in 1..255");
  end
  if (ENGINE_ID < 0) begin : g_id_chk
    $error("ENGINE_ID must be non-negative");
  end

  localparam logic [7:0] BURST_MAX = 8'(SPIKE_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
    return (v == lim) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] burst_cnt_q;
  logic       spike_v, time_v, grant_time, grant_spike, idle_rdy;
  logic       spike_hs, time_hs, acc_hs, drop_evt;
  logic       vld_p1, busy;
  sne_evt_t   acc_evt, evt_p1;

  assign spike_v = evt_stream_spike_dst.valid;
  assign time_v  = evt_stream_time_dst.valid;

  // Time wins only when alone or when the spike burst allowance is used up.
  assign grant_time  = enable_i && time_v && (!spike_v || burst_cnt_q == BURST_MAX);
  assign grant_spike = enable_i && spike_v && !grant_time;
  assign idle_rdy    = rst_ni && (state_q == ST_IDLE);

  assign evt_stream_spike_dst.ready = idle_rdy && grant_spike;
  assign evt_stream_time_dst.ready  = idle_rdy && grant_time;

  assign spike_hs = evt_stream_spike_dst.ready && spike_v;
  assign time_hs  = evt_stream_time_dst.ready && time_v;
  assign acc_hs   = spike_hs || time_hs;
  assign acc_evt  = time_hs ? evt_stream_time_dst.evt : evt_stream_spike_dst.evt;

`ifdef EVT_ENGINE_MERGER_OP_CHECK_EN
  function automatic logic is_time_op(input logic [3:0] op);
    return (op == EVT_TIME) || (op == EVT_SYNCH);
  endfunction

  assign drop_evt = time_hs ? !is_time_op(evt_stream_time_dst.evt.spike.operation)
                            : is_time_op(evt_stream_spike_dst.evt.spike.operation);

  logic [15:0] err_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              err_cnt_q <= '0;
    else if (acc_hs && drop_evt) err_cnt_q <= sat_inc16(err_cnt_q);
  end
  assign err_cnt_o = err_cnt_q;
`else
  assign drop_evt  = 1'b0;
  assign err_cnt_o = sat_inc16(16'hFFFF) & 16'h0000;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 burst_cnt_q <= '0;
    else if (!time_v || time_hs) burst_cnt_q <= '0;
    else if (spike_hs)           burst_cnt_q <= sat_inc8(burst_cnt_q, BURST_MAX);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = acc_hs ? (drop_evt ? ST_DROP : ST_SEND) : ST_IDLE;
      ST_SEND: state_d = evt_stream_engine_src.ready ? ST_IDLE : ST_SEND;
      ST_DROP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_p1 = 1'b0;
    busy   = 1'b0;
    case (state_q)
      ST_SEND: begin
        vld_p1 = 1'b1;
        busy   = 1'b1;
      end
      ST_DROP: busy = 1'b1;
      default: ;
    endcase
  end

  // ---- stage p1: output register (data only, masked while not valid) ----
  always_ff @(posedge clk_i) begin
    if (acc_hs) evt_p1 <= acc_evt;
  end

  assign evt_stream_engine_src.valid = vld_p1;
  assign evt_stream_engine_src.evt   = vld_p1 ? evt_p1 : '0;
  assign busy_o                      = busy;

endmodule

// File: tb/tb_evt_engine_merger.sv
// Directed self-checking bench for evt_engine_merger (SPIKE_BURST = 4).
module tb_evt_engine_merger;
  import sne_evt_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        enable;
  logic [15:0] err_cnt;
  logic        busy;
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_chk  = 0;

  SNE_EVENT_STREAM spike_if ();
  SNE_EVENT_STREAM time_if ();
  SNE_EVENT_STREAM eng_if ();

  evt_engine_merger #(.ENGINE_ID(3), .SPIKE_BURST(4)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .enable_i              (enable),
    .evt_stream_spike_dst  (spike_if),
    .evt_stream_time_dst   (time_if),
    .evt_stream_engine_src (eng_if),
    .err_cnt_o             (err_cnt),
    .busy_o                (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic sne_evt_t mk(input logic [3:0] op, input logic [15:0] pl);
    sne_evt_t e;
    e = '0;
    e.spike.operation = op;
    e.spike.unit_id   = 4'h3;
    e.spike.cid       = 8'h5A;
    e.spike.payload   = pl;
    return e;
  endfunction

  initial begin
    sne_evt_t   ev_a, ev_b, ev_c, ev_d, ev_e, ev_f, ev_x;
    logic [9:0] order;
    order = 10'b1000010000;

    rst_ni         = 1'b0;
    enable         = 1'b0;
    spike_if.valid = 1'b0;
    spike_if.evt   = '0;
    time_if.valid  = 1'b0;
    time_if.evt    = '0;
    eng_if.ready   = 1'b0;

    // Reset state, with inputs trying to get in.
    #2;
    enable         = 1'b1;
    spike_if.valid = 1'b1;
    spike_if.evt   = mk(EVT_SPIKE, 16'h0001);
    #1;
    check("rst_spike_rdy", spike_if.ready, 0);
    check("rst_time_rdy", time_if.ready, 0);
    check("rst_eng_vld", eng_if.valid, 0);
    check("rst_eng_evt", eng_if.evt, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_cnt, 0);
    spike_if.valid = 1'b0;
    enable         = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    tick();

    // Single spike: accept in cycle 0, output in cycle 1, idle in cycle 2.
    ev_a           = mk(EVT_SPIKE, 16'h1234);
    spike_if.valid = 1'b1;
    spike_if.evt   = ev_a;
    eng_if.ready   = 1'b1;
    enable         = 1'b1;
    #1;
    check("c0_spike_rdy", spike_if.ready, 1);
    check("c0_time_rdy", time_if.ready, 0);
    tick();
    spike_if.valid = 1'b0;
    spike_if.evt   = mk(EVT_WIPE, 16'hDEAD);
    #1;
    check("c1_vld", eng_if.valid, 1);
    check("c1_evt", eng_if.evt, ev_a);
    check("c1_busy", busy, 1);
    check("c1_spike_rdy", spike_if.ready, 0);
    tick();
    check("c2_vld", eng_if.valid, 0);
    check("c2_evt", eng_if.evt, 0);
    check("c2_busy", busy, 0);

    // Engine back-pressure for 10 cycles; output must hold.
    ev_b           = mk(EVT_ACCUMULATE, 16'h0BEE);
    spike_if.valid = 1'b1;
    spike_if.evt   = ev_b;
    eng_if.ready   = 1'b0;
    #1;
    check("hold_accept_rdy", spike_if.ready, 1);
    tick();
    spike_if.evt = mk(EVT_UPDATE, 16'h0C0C);
    for (int i = 0; i < 10; i++) begin
      enable = (i % 3) != 1;
      #1;
      check("hold_vld", eng_if.valid, 1);
      check("hold_evt", eng_if.evt, ev_b);
      check("hold_spike_rdy", spike_if.ready, 0);
      tick();
    end
    enable         = 1'b1;
    eng_if.ready   = 1'b1;
    spike_if.valid = 1'b0;
    #1;
    check("release_vld", eng_if.valid, 1);
    check("release_evt", eng_if.evt, ev_b);
    tick();
    check("post_release_vld", eng_if.valid, 0);
    check("post_release_busy", busy, 0);

    // Disabled with both valid: nothing moves.
    enable         = 1'b0;
    spike_if.valid = 1'b1;
    time_if.valid  = 1'b1;
    spike_if.evt   = mk(EVT_SPIKE, 16'h0000);
    time_if.evt    = mk(EVT_TIME, 16'h0100);
    eng_if.ready   = 1'b1;
    repeat (3) begin
      #1;
      check("dis_spike_rdy", spike_if.ready, 0);
      check("dis_time_rdy", time_if.ready, 0);
      check("dis_vld", eng_if.valid, 0);
      tick();
    end

    // Enabled, both valid continuously: S,S,S,S,T,S,S,S,S,T.
    enable = 1'b1;
    for (int g = 0; g < 10; g++) begin
      spike_if.evt = mk(EVT_SPIKE, 16'(g));
      time_if.evt  = mk(EVT_TIME, 16'(16'h0100 + g));
      #1;
      check("grant_time_rdy", time_if.ready, order[g]);
      check("grant_spike_rdy", spike_if.ready, !order[g]);
      ev_x = order[g] ? mk(EVT_TIME, 16'(16'h0100 + g)) : mk(EVT_SPIKE, 16'(g));
      tick();
      check("grant_out_vld", eng_if.valid, 1);
      check("grant_out_evt", eng_if.evt, ev_x);
      check("grant_out_rdys", spike_if.ready | time_if.ready, 0);
      tick();
    end
    spike_if.valid = 1'b0;
    time_if.valid  = 1'b0;

    // Mis-classed events on both ports.
    ev_c           = mk(EVT_TIME, 16'h0777);
    spike_if.valid = 1'b1;
    spike_if.evt   = ev_c;
    #1;
    check("mc_spike_rdy", spike_if.ready, 1);
    tick();
    spike_if.valid = 1'b0;
    ev_d           = mk(4'hF, 16'h0888);
`ifdef EVT_ENGINE_MERGER_OP_CHECK_EN
    check("mc_vld", eng_if.valid, 0);
    check("mc_busy", busy, 1);
    check("mc_err", err_cnt, 1);
    tick();
    check("mc_idle_busy", busy, 0);
    time_if.valid = 1'b1;
    time_if.evt   = ev_d;
    #1;
    check("mt_time_rdy", time_if.ready, 1);
    tick();
    time_if.valid = 1'b0;
    check("mt_vld", eng_if.valid, 0);
    check("mt_err", err_cnt, 2);
    tick();
    check("mt_idle_busy", busy, 0);
`else
    check("mc_vld", eng_if.valid, 1);
    check("mc_evt", eng_if.evt, ev_c);
    check("mc_err", err_cnt, 0);
    tick();
    check("mc_idle_vld", eng_if.valid, 0);
    time_if.valid = 1'b1;
    time_if.evt   = ev_d;
    #1;
    check("mt_time_rdy", time_if.ready, 1);
    tick();
    time_if.valid = 1'b0;
    check("mt_vld", eng_if.valid, 1);
    check("mt_evt", eng_if.evt, ev_d);
    check("mt_err", err_cnt, 0);
    tick();
`endif

    // Reset pulsed during a stalled SEND.
    ev_e           = mk(EVT_SPIKE, 16'h0E0E);
    ev_f           = mk(EVT_WIPE, 16'h0F0F);
    spike_if.valid = 1'b1;
    spike_if.evt   = ev_e;
    eng_if.ready   = 1'b0;
    #1;
    tick();
    spike_if.evt = ev_f;
    check("rs_send_vld", eng_if.valid, 1);
    eng_if.ready = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    check("rs_vld", eng_if.valid, 0);
    check("rs_evt", eng_if.evt, 0);
    check("rs_busy", busy, 0);
    check("rs_err", err_cnt, 0);
    check("rs_spike_rdy", spike_if.ready, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    check("rel_vld", eng_if.valid, 0);
    check("rel_spike_rdy", spike_if.ready, 1);
    tick();
    spike_if.valid = 1'b0;
    check("rel_fwd_vld", eng_if.valid, 1);
    check("rel_fwd_evt", eng_if.evt, ev_f);
    tick();
    check("rel_idle_vld", eng_if.valid, 0);
    check("rel_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
